chacha_round_ctrl: RTL

//  Round sequencer that sits upstream and downstream of the registered ChaCha quarterround (QR) stage.

---
 rtl/chacha_round_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chacha_round_ctrl.sv
// chacha_round_ctrl: ChaCha round sequencer around an external registered quarterround stage.
// Ports: clk, reset (sync, active-high); start/ready accept a 512-bit state_in (word i = [32*i +: 32]);
//   qr_a..qr_d issue one quarterround per cycle; qr_*_prim return its result one cycle later;
//   block_out/valid present the finished block until ack.
// Build option: define CHACHA_RC_FEEDFWD_EN to add the input state into the result (standard block
//   function); otherwise block_out is the raw permuted state and no copy of the input is kept.
module chacha_round_ctrl #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic [511:0] state_in,
  output logic [31:0]  qr_a,
  output logic [31:0]  qr_b,
  output logic [31:0]  qr_c,
  output logic [31:0]  qr_d,
  input  logic [31:0]  qr_a_prim,
  input  logic [31:0]  qr_b_prim,
  input  logic [31:0]  qr_c_prim,
  input  logic [31:0]  qr_d_prim,
  output logic [511:0] block_out,
  output logic         valid,
  input  logic         ack
);
  localparam int RW = $clog2(ROUNDS);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINAL, DONE} state_t;
  state_t         state_q, state_d;
  logic [RW-1:0]  round_q, round_d;
  logic [1:0]     idx_q, idx_d;
  logic [511:0]   work_q, work_d;
  logic [511:0]   block_q, block_d;
`ifdef CHACHA_RC_FEEDFWD_EN
  logic [511:0]   init_q, init_d;
`endif
  logic [31:0]    prim [4];
  logic           issuing, wb_en;
  logic [1:0]     wb_qr;
  // Bit offset of operand pos of quarterround qr: column rounds keep the lane, diagonal rounds
  // rotate lane by the operand position, giving (0,5,10,15) (1,6,11,12) ...
  function automatic logic [8:0] wbase(input logic diag, input logic [1:0] qr, input logic [1:0] pos);
    logic [1:0] lane;
    lane = qr + (diag ? pos : 2'd0);
    return {pos, lane, 5'd0};
  endfunction
  assign prim[0] = qr_a_prim;
  assign prim[1] = qr_b_prim;
  assign prim[2] = qr_c_prim;
  assign prim[3] = qr_d_prim;
  assign issuing = state_q == ISSUE;
  // The result of the quarterround issued last cycle arrives now; DRAIN collects the fourth one.
  assign wb_en   = (issuing && idx_q != 2'd0) || state_q == DRAIN;
  assign wb_qr   = state_q == DRAIN ? 2'd3 : idx_q - 2'd1;
  assign qr_a = issuing ? work_q[wbase(round_q[0], idx_q, 2'd0) +: 32] : '0;
  assign qr_b = issuing ? work_q[wbase(round_q[0], idx_q, 2'd1) +: 32] : '0;
  assign qr_c = issuing ? work_q[wbase(round_q[0], idx_q, 2'd2) +: 32] : '0;
  assign qr_d = issuing ? work_q[wbase(round_q[0], idx_q, 2'd3) +: 32] : '0;
  assign ready     = state_q == IDLE;
  assign valid     = state_q == DONE;
  assign block_out = block_q;
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d   = idx_q;
    work_d  = work_q;
    block_d = block_q;
`ifdef CHACHA_RC_FEEDFWD_EN
    init_d  = init_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        round_d = '0;
        idx_d   = '0;
        work_d  = state_in;
`ifdef CHACHA_RC_FEEDFWD_EN
        init_d  = state_in;
`endif
      end
      ISSUE: begin
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? DRAIN : ISSUE;
      end
      DRAIN: begin
        round_d = round_q + 1'b1;
        state_d = round_q == RW'(ROUNDS - 1) ? FINAL : ISSUE;
      end
      FINAL: begin
`ifdef CHACHA_RC_FEEDFWD_EN
        for (int i = 0; i < 16; i++) block_d[32*i +: 32] = work_q[32*i +: 32] + init_q[32*i +: 32];
`else
        block_d = work_q;
`endif
        state_d = DONE;
      end
      DONE:    state_d = ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (wb_en)
      for (int p = 0; p < 4; p++) work_d[wbase(round_q[0], wb_qr, 2'(p)) +: 32] = prim[p];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      idx_q   <= '0;
      work_q  <= '0;
      block_q <= '0;
`ifdef CHACHA_RC_FEEDFWD_EN
      init_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      block_q <= block_d;
`ifdef CHACHA_RC_FEEDFWD_EN
      init_q  <= init_d;
`endif
    end
  end
endmodule
